// File: rtl/calc_pkg.sv
// Shared button indices and entry-FSM state type for the calculator input front end.
package calc_pkg;

    localparam int BTN_CLR = 0;
    localparam int BTN_ADD = 1;
    localparam int BTN_MUL = 2;
    localparam int BTN_DIV = 3;
    localparam int BTN_MOD = 4;
    localparam int NUM_BTN = 5;

    localparam logic [NUM_BTN-1:0] CLR_CMD = NUM_BTN'(1) << BTN_CLR;

    typedef enum logic [1:0] {READY, LOAD, ISSUE, BUSY} in_state_t;

    // Commands that divide by the second operand.
    function automatic logic is_div_op(input logic [NUM_BTN-1:0] op);
        return op[BTN_DIV] | op[BTN_MOD];
    endfunction

endpackage

// File: rtl/calc_input_ctrl_btn_debounce.sv
// One push-button: 2-FF synchroniser, stability counter and rising-edge press pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;
            press   <= level & ~level_q;
            // The counter only runs while the input disagrees with the accepted level.
            if (sync2 != level) begin
                if (cnt >= LAST) begin
                    level <= ~level;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/calc_input_ctrl.sv
// Calculator front end: debounced buttons, operand capture and one-hot command pulses.
// Optional divide-by-zero guard enabled by defining DIV_GUARD_EN.
module calc_input_ctrl
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTN-1:0]  btn_raw,
    input  logic [15:0]         sw,
    output logic [NUM_BTN-1:0]  buttons,
    output logic signed [7:0]   first,
    output logic signed [7:0]   second,
    output logic                busy,
    output logic                err
);

    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] op_press;
    logic [NUM_BTN-1:0] op;
    logic [NUM_BTN-1:0] op_d;
    logic [NUM_BTN-1:0] buttons_d;
    logic signed [7:0]  first_d;
    logic signed [7:0]  second_d;
    logic               busy_d;
    logic               err_d;
    in_state_t          state;
    in_state_t          state_d;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk  (clk),
            .reset(reset),
            .raw  (btn_raw[i]),
            .press(press[i])
        );
    end

    assign op_press = press & ~CLR_CMD;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state;
        op_d      = op;
        buttons_d = '0;
        first_d   = first;
        second_d  = second;
        busy_d    = busy;
        err_d     = err;
        if (press[BTN_CLR]) begin
            // Clear wins in every state and drops any pending op.
            buttons_d = CLR_CMD;
            busy_d    = 1'b0;
            err_d     = 1'b0;
            state_d   = READY;
        end else begin
            case (state)
                READY: begin
                    if ($onehot(op_press)) begin
                        op_d    = op_press;
                        state_d = LOAD;
                    end
                end
                LOAD: begin
                    first_d  = sw[15:8];
                    second_d = sw[7:0];
                    busy_d   = 1'b1;
                    state_d  = ISSUE;
`ifdef DIV_GUARD_EN
                    if (is_div_op(op) && sw[7:0] == 8'd0) begin
                        err_d   = 1'b1;
                        state_d = BUSY;
                    end
`endif
                end
                ISSUE: begin
                    buttons_d = op;
                    state_d   = BUSY;
                end
                BUSY:    state_d = BUSY;
                default: state_d = READY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= READY;
            op      <= '0;
            buttons <= '0;
            first   <= '0;
            second  <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_d;
            op      <= op_d;
            buttons <= buttons_d;
            first   <= first_d;
            second  <= second_d;
            busy    <= busy_d;
            err     <= err_d;
        end
    end

endmodule

// File: tb/tb_calc_input_ctrl.sv
// Self-checking bench for calc_input_ctrl: directed table, corner sequences and random traffic
// compared cycle by cycle against a behavioural model.
module tb_calc_input_ctrl;

    localparam int DEB   = 4;
    localparam int CNT_W = 3;
`ifdef DIV_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  btn_raw;
    logic [15:0] sw;
    logic [4:0]  buttons;
    logic [7:0]  first;
    logic [7:0]  second;
    logic        busy;
    logic        err;

    calc_input_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .sw     (sw),
        .buttons(buttons),
        .first  (first),
        .second (second),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Debounce: a button's accepted level flips once its synchronised value (raw delayed by two
    // clocks) has disagreed with it for DEB consecutive clocks; a rise gives a press one clock later.
    // Commands: an accepted single op schedules an operand latch one clock later and the pulse
    // one clock after that; clear always wins and cancels whatever is scheduled.
    bit          hist [5][DEB+1];
    bit          lvl  [5];
    bit          rose [5];
    logic [4:0]  m_press   = '0;
    logic [4:0]  m_buttons = '0;
    logic [4:0]  m_op      = '0;
    logic [7:0]  m_first   = '0;
    logic [7:0]  m_second  = '0;
    bit          m_busy    = 1'b0;
    bit          m_err     = 1'b0;
    int          m_sched   = 0;

    task automatic model_edge();
        logic [4:0] ops;
        logic [4:0] nb;
        bit         all_diff;
        if (reset) begin
            for (int b = 0; b < 5; b++) begin
                for (int k = 0; k <= DEB; k++) hist[b][k] = 1'b0;
                lvl[b]  = 1'b0;
                rose[b] = 1'b0;
            end
            m_press = '0; m_buttons = '0; m_op = '0; m_first = '0; m_second = '0;
            m_busy = 1'b0; m_err = 1'b0; m_sched = 0;
            return;
        end
        nb  = '0;
        ops = m_press & 5'b11110;
        if (m_press[0]) begin
            nb = 5'b00001; m_busy = 1'b0; m_err = 1'b0; m_sched = 0;
        end else if (m_sched == 2) begin
            m_first  = sw[15:8];
            m_second = sw[7:0];
            m_busy   = 1'b1;
            if (GUARD && (m_op[3] || m_op[4]) && sw[7:0] == 8'd0) begin
                m_err = 1'b1; m_sched = 0;
            end else begin
                m_sched = 1;
            end
        end else if (m_sched == 1) begin
            nb = m_op; m_sched = 0;
        end else if (!m_busy && $countones(ops) == 1) begin
            m_op = ops; m_sched = 2;
        end
        m_buttons = nb;
        for (int b = 0; b < 5; b++) begin
            m_press[b] = rose[b];
            all_diff = 1'b1;
            for (int k = 1; k <= DEB; k++) if (hist[b][k] == lvl[b]) all_diff = 1'b0;
            rose[b] = 1'b0;
            if (all_diff) begin
                lvl[b]  = ~lvl[b];
                rose[b] = lvl[b];
            end
            for (int k = DEB; k >= 1; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = btn_raw[b];
        end
    endtask

    // ---------------- per-clock driver / observer ----------------
    int         t_rel;
    int         pulses;
    int         first_pulse;
    logic [4:0] pulse_or;

    task automatic clear_obs();
        t_rel = 0; pulses = 0; first_pulse = 0; pulse_or = '0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        t_rel++;
        check("cycle", {buttons, first, second, busy, err},
              {m_buttons, m_first, m_second, m_busy, m_err});
        if (buttons != '0) begin
            pulses++;
            pulse_or |= buttons;
            if (first_pulse == 0) first_pulse = t_rel;
        end
    endtask

    task automatic press_release(input logic [15:0] s, input logic [4:0] b, input int hold, input int rest);
        sw = s;
        btn_raw = b;
        repeat (hold) tick();
        btn_raw = '0;
        repeat (rest) tick();
    endtask

    typedef struct {
        string      name;
        logic [15:0] sw;
        logic [4:0] btn;
        logic [4:0] exp_or;
        int         exp_cnt;
        int         exp_lat;
        logic [7:0] exp_first;
        logic [7:0] exp_second;
        bit         exp_busy;
        bit         exp_err;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // latency from first clock with raw asserted: press at 7, clear pulse at 8, op pulse at 10
        vecs[0] = '{"add",       16'h05FD, 5'b00010, 5'b00010, 1, 10, 8'h05, 8'hFD, 1'b1, 1'b0};
        vecs[1] = '{"clr_add",   16'h1234, 5'b00001, 5'b00001, 1,  8, 8'h05, 8'hFD, 1'b0, 1'b0};
        vecs[2] = '{"mul",       16'h807F, 5'b00100, 5'b00100, 1, 10, 8'h80, 8'h7F, 1'b1, 1'b0};
        vecs[3] = '{"clr_mul",   16'h0000, 5'b00001, 5'b00001, 1,  8, 8'h80, 8'h7F, 1'b0, 1'b0};
        vecs[4] = '{"add_mul",   16'h1111, 5'b00110, 5'b00000, 0,  0, 8'h80, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{"clr_wins",  16'h2222, 5'b00011, 5'b00001, 1,  8, 8'h80, 8'h7F, 1'b0, 1'b0};
`ifdef DIV_GUARD_EN
        vecs[6] = '{"div_zero",  16'h0700, 5'b01000, 5'b00000, 0,  0, 8'h07, 8'h00, 1'b1, 1'b1};
`else
        vecs[6] = '{"div_zero",  16'h0700, 5'b01000, 5'b01000, 1, 10, 8'h07, 8'h00, 1'b1, 1'b0};
`endif
        vecs[7] = '{"clr_div",   16'h3333, 5'b00001, 5'b00001, 1,  8, 8'h07, 8'h00, 1'b0, 1'b0};
        vecs[8] = '{"mod",       16'hFB03, 5'b10000, 5'b10000, 1, 10, 8'hFB, 8'h03, 1'b1, 1'b0};
        vecs[9] = '{"clr_mod",   16'h4444, 5'b00001, 5'b00001, 1,  8, 8'hFB, 8'h03, 1'b0, 1'b0};

        reset = 1'b1; btn_raw = '0; sw = 16'hA5A5;
        clear_obs();
        repeat (3) tick();
        check("reset_buttons", {27'd0, buttons}, 32'd0);
        check("reset_first",   {24'd0, first},   32'd0);
        check("reset_busy",    {31'd0, busy},    32'd0);
        check("reset_err",     {31'd0, err},     32'd0);
        reset = 1'b0;
        repeat (3) tick();

        // ---- directed table ----
        for (int i = 0; i < 10; i++) begin
            clear_obs();
            press_release(vecs[i].sw, vecs[i].btn, 10, 20);
            check({vecs[i].name, "_pulse"},   {27'd0, pulse_or}, {27'd0, vecs[i].exp_or});
            check({vecs[i].name, "_count"},   pulses,            vecs[i].exp_cnt);
            check({vecs[i].name, "_latency"}, first_pulse,       vecs[i].exp_lat);
            check({vecs[i].name, "_first"},   {24'd0, first},    {24'd0, vecs[i].exp_first});
            check({vecs[i].name, "_second"},  {24'd0, second},   {24'd0, vecs[i].exp_second});
            check({vecs[i].name, "_busy"},    {31'd0, busy},     {31'd0, vecs[i].exp_busy});
            check({vecs[i].name, "_err"},     {31'd0, err},      {31'd0, vecs[i].exp_err});
        end

        // ---- bouncing mul never accepted ----
        clear_obs();
        sw = 16'h0909;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2 == 0) ? 5'b00100 : 5'b00000;
            tick();
        end
        btn_raw = '0;
        repeat (20) tick();
        check("bounce_count", pulses, 0);
        check("bounce_busy",  {31'd0, busy}, 32'd0);

        // ---- busy ignores ops and switch changes ----
        press_release(16'h0102, 5'b00010, 10, 20);
        check("busy_set", {31'd0, busy}, 32'd1);
        clear_obs();
        press_release(16'h7F7F, 5'b00100, 10, 20);
        check("busy_ignore_count", pulses, 0);
        check("busy_hold_first",   {24'd0, first},  32'h01);
        check("busy_hold_second",  {24'd0, second}, 32'h02);
        clear_obs();
        press_release(16'h7F7F, 5'b00001, 10, 20);
        check("busy_clear_pulse", {27'd0, pulse_or}, 32'h01);
        check("busy_clear_count", pulses, 1);
        check("busy_clear_busy",  {31'd0, busy}, 32'd0);

        // ---- reset in ISSUE with add held ----
        clear_obs();
        sw = 16'h0304;
        btn_raw = 5'b00010;
        repeat (9) tick();
        check("issue_busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("rst_mid_outputs", {buttons, first, second, busy, err}, 32'd0);
        reset = 1'b0;
        clear_obs();
        repeat (30) tick();
        check("rst_held_count",   pulses, 1);
        check("rst_held_pulse",   {27'd0, pulse_or}, 32'h02);
        check("rst_held_latency", first_pulse, 10);
        btn_raw = '0;
        repeat (20) tick();
        press_release(16'h0000, 5'b00001, 10, 20);

        // ---- random traffic against the model ----
        for (int seg = 0; seg < 150; seg++) begin
            int         r;
            logic [4:0] b;
            logic [15:0] s;
            r = $urandom_range(0, 9);
            if (r <= 1)      b = 5'b00001;
            else if (r <= 6) b = 5'(1 << $urandom_range(1, 4));
            else if (r == 7) b = 5'(1 << $urandom_range(1, 2)) | 5'(1 << $urandom_range(3, 4));
            else if (r == 8) b = '0;
            else             b = 5'($urandom);
            s = 16'($urandom);
            if ($urandom_range(0, 3) == 0) s[7:0] = 8'd0;
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            press_release(s, b, $urandom_range(1, 12), $urandom_range(0, 10));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
